inst_fetch: RTL

- Instruction-fetch front end that drives the instruction ROM.
- Owns the program counter and presents `InstAddrBus`-wide addresses to the ROM; the ROM returns `InstBusWidth` instructions combinationally in the same cycle.
- Registers each fetched instruction and its PC into a one-stage fetch/decode pipeline register for the decoder.
- Accepts stall, skip (BEQ/BNE "PC+2") and jump (JMP) redirects from decode/execute.

---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/inst_fetch_pc_next_sel.sv | 36 +++
 rtl/inst_fetch.sv | 99 +++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared architecture constants for the fetch front end: bus widths, the NOP
// encoding used by ROM and decode, and the next-PC selection codes.
package inst_fetch_pkg;

  localparam int INST_ADDR_BUS  = 10;
  localparam int INST_BUS_WIDTH = 32;

  typedef logic [INST_ADDR_BUS-1:0]  inst_addr_t;
  typedef logic [INST_BUS_WIDTH-1:0] inst_t;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam inst_t      NOP_INST = {OP_NOP, 26'b0};

  localparam inst_addr_t ADDR_ZERO = {INST_ADDR_BUS{1'b0}};
  localparam inst_addr_t ADDR_ONE  = {{(INST_ADDR_BUS-1){1'b0}}, 1'b1};
  localparam inst_addr_t ADDR_TWO  = {{(INST_ADDR_BUS-2){1'b0}}, 2'b10};

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_HOLD = 2'd1,
    SEL_JUMP = 2'd2,
    SEL_SKIP = 2'd3
  } pc_sel_e;

  // Modulo-2^INST_ADDR_BUS address add; overflow wraps silently.
  function automatic inst_addr_t addr_add(input inst_addr_t a, input inst_addr_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/inst_fetch_pc_next_sel.sv
// Combinational next-PC mux: stall > jump > skip > sequential. Redirects are
// only honoured while the instruction in the pipeline register is valid.
module pc_next_sel
  import inst_fetch_pkg::*;
(
  input  logic       stall,
  input  logic       valid,
  input  logic       jump_en,
  input  logic       skip_en,
  input  inst_addr_t jump_target,
  input  inst_addr_t pc,
  input  inst_addr_t pc_out,
  output inst_addr_t pc_next,
  output pc_sel_e    sel
);

  // Priority selection of the PC for the next edge.
  always_comb begin
    sel     = SEL_SEQ;
    pc_next = addr_add(pc, ADDR_ONE);
    if (stall) begin
      sel     = SEL_HOLD;
      pc_next = pc;
    end else if (valid && jump_en) begin
      sel     = SEL_JUMP;
      pc_next = jump_target;
    end else if (valid && skip_en) begin
      sel     = SEL_SKIP;
      pc_next = addr_add(pc_out, ADDR_TWO);
    end else begin
      sel     = SEL_SEQ;
      pc_next = addr_add(pc, ADDR_ONE);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, addresses the combinational ROM and
// registers instruction/PC into the fetch/decode pipeline register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = {INST_ADDR_BUS{1'b0}},
  parameter int                       CNT_W    = 32
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      skip_en,
  input  logic                      jump_en,
  input  logic [INST_ADDR_BUS-1:0]  jump_target,
  output logic [INST_ADDR_BUS-1:0]  rom_addr,
  input  logic [INST_BUS_WIDTH-1:0] rom_inst,
  output logic [INST_BUS_WIDTH-1:0] inst_out,
  output logic [INST_ADDR_BUS-1:0]  pc_out,
  output logic                      inst_valid,
  output logic [CNT_W-1:0]          fetch_count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  inst_addr_t       pc_r;
  inst_t            inst_r;
  inst_addr_t       pc_out_r;
  logic             valid_r;
  logic [CNT_W-1:0] count_r;

  inst_addr_t pc_next_s;
  pc_sel_e    sel_s;

  pc_next_sel u_pc_next_sel (
    .stall       (stall),
    .valid       (valid_r),
    .jump_en     (jump_en),
    .skip_en     (skip_en),
    .jump_target (jump_target),
    .pc          (pc_r),
    .pc_out      (pc_out_r),
    .pc_next     (pc_next_s),
    .sel         (sel_s)
  );

  // PC and fetch/decode pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      inst_r   <= NOP_INST;
      pc_out_r <= ADDR_ZERO;
      valid_r  <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      case (sel_s)
        SEL_SEQ: begin
          inst_r   <= rom_inst;
          pc_out_r <= pc_r;
          valid_r  <= 1'b1;
        end
        SEL_JUMP: begin
          inst_r   <= NOP_INST;
          valid_r  <= 1'b0;
        end
        SEL_SKIP: begin
          valid_r  <= 1'b0;
        end
        SEL_HOLD: begin
          valid_r  <= valid_r;
        end
        default: begin
          inst_r   <= NOP_INST;
          valid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of valid instructions delivered to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if ((sel_s == SEL_SEQ) && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign rom_addr    = pc_r;
  assign inst_out    = inst_r;
  assign pc_out      = pc_out_r;
  assign inst_valid  = valid_r;
  assign fetch_count = count_r;

endmodule
